// File: rtl/debug_reg_reader_pkg.sv
// Shared debug-display definitions: seven-segment glyphs, the digit table and
// the read FSM state type used by the register-file debug reader.
package debug_reg_reader_pkg;

  localparam int SEL_W_DEF = 5;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    SEG_ZERO     // 0
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/debug_reg_reader_hex_to_7seg.sv
// One hex digit: 4-bit nibble to active-low seven-segment pattern.
module hex_to_7seg
  import debug_reg_reader_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/debug_reg_reader.sv
// Board debugger front end: synchronises the selector switches, reads the chosen
// register over a req/ack port with periodic refresh and timeout, shows it on HEX7..HEX0.
module debug_reg_reader
  import debug_reg_reader_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int SEL_W          = SEL_W_DEF,
  parameter int REFRESH_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  Debug_selector,
  output logic              dbg_rd_req,
  output logic [SEL_W-1:0]  dbg_rd_addr,
  input  logic              dbg_rd_ack,
  input  logic [DATA_W-1:0] dbg_rd_data,
  output logic              dbg_valid,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5,
  output logic [6:0]        HEX6,
  output logic [6:0]        HEX7
);

  localparam int NUM_DIGITS = 8;
  localparam int DISP_W     = NUM_DIGITS * 4;
  localparam int RW         = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0][SEL_W-1:0] sync_q;
  logic [SEL_W-1:0]      sel_s;
  dbg_state_e            state, state_nx;
  logic [SEL_W-1:0]      last_addr;
  logic                  pending;
  logic [RW-1:0]         rcnt;
  logic [TW-1:0]         tcnt;
  logic [DATA_W-1:0]     value;
  logic                  err;
  logic                  start, done_ok, done_tmo;

  // Switch inputs are asynchronous; sync_q[1] is the first usable copy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], Debug_selector};
  end
  assign sel_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Ack wins over timeout when both land on the last allowed cycle
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((sel_s != last_addr) || pending || (rcnt == REF_LAST)) begin
          start    = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dbg_rd_ack) begin
          done_ok  = 1'b1;
          state_nx = ST_IDLE;
        end else if (tcnt == TMO_LAST) begin
          done_tmo = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign dbg_rd_req = (state == ST_REQ);

  // Address is captured once per transaction; later switch moves are deferred via pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_rd_addr <= '0;
      last_addr   <= '0;
      pending     <= 1'b0;
      tcnt        <= '0;
    end else if (start) begin
      dbg_rd_addr <= sel_s;
      last_addr   <= sel_s;
      pending     <= 1'b0;
      tcnt        <= '0;
    end else if (state == ST_REQ) begin
      if (sel_s != last_addr) pending <= 1'b1;
      if (!dbg_rd_ack && (tcnt != TMO_LAST)) tcnt <= tcnt + 1'b1;
    end
  end

  // Refresh counter only advances while idle and holds at the threshold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
    end else if (done_ok) begin
      rcnt <= '0;
    end else if ((state == ST_IDLE) && (rcnt != REF_LAST)) begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value     <= '0;
      err       <= 1'b0;
      dbg_valid <= 1'b0;
    end else if (done_ok) begin
      value     <= dbg_rd_data;
      err       <= 1'b0;
      dbg_valid <= 1'b1;
    end else if (done_tmo) begin
      err       <= 1'b1;
      dbg_valid <= 1'b0;
    end
  end

  logic [DISP_W-1:0]                disp_val;
  logic [NUM_DIGITS-1:0][6:0]       dig_seg;
  logic [NUM_DIGITS-1:0][6:0]       hex;

  assign disp_val = DISP_W'(value);

  hex_to_7seg u_dig [NUM_DIGITS-1:0] (
    .nibble (disp_val),
    .seg    (dig_seg)
  );

  assign hex = err ? {NUM_DIGITS{SEG_DASH}} : dig_seg;

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];
  assign HEX6 = hex[6];
  assign HEX7 = hex[7];

endmodule

// File: tb/tb_debug_reg_reader.sv
// Bench for debug_reg_reader: directed scenarios then random traffic, every cycle
// compared against a timestamp-based behavioural model of the reader.
module tb_debug_reg_reader;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 5;
  localparam int R      = 64;
  localparam int T      = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [SEL_W-1:0]  Debug_selector;
  logic              dbg_rd_req;
  logic [SEL_W-1:0]  dbg_rd_addr;
  logic              dbg_rd_ack;
  logic [DATA_W-1:0] dbg_rd_data;
  logic              dbg_valid;
  logic [6:0]        HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [6:0]        hex_w [8];

  debug_reg_reader #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .REFRESH_CYCLES(R), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .Debug_selector(Debug_selector),
    .dbg_rd_req(dbg_rd_req), .dbg_rd_addr(dbg_rd_addr),
    .dbg_rd_ack(dbg_rd_ack), .dbg_rd_data(dbg_rd_data), .dbg_valid(dbg_valid),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );

  always #5 clk = ~clk;

  assign hex_w[0] = HEX0;
  assign hex_w[1] = HEX1;
  assign hex_w[2] = HEX2;
  assign hex_w[3] = HEX3;
  assign hex_w[4] = HEX4;
  assign hex_w[5] = HEX5;
  assign hex_w[6] = HEX6;
  assign hex_w[7] = HEX7;

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] ZERO = 7'b1000000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  logic [31:0] regs [32];
  int          sel_hist [2];   // selector seen at the last two edges (oldest in [1])
  bit          m_busy;
  int          m_addr, m_last;
  bit          m_pend;
  int          m_idle_seen;    // idle edges since the last successful read
  longint      cyc, m_start;
  logic [31:0] m_val;
  bit          m_err, m_valid;

  function automatic void model_reset();
    sel_hist[0] = 0; sel_hist[1] = 0;
    m_busy = 0; m_addr = 0; m_last = 0; m_pend = 0;
    m_idle_seen = 0; m_start = 0;
    m_val = '0; m_err = 0; m_valid = 0;
  endfunction

  function automatic void model_step(input int sel_in, input bit ack_in, input logic [31:0] d_in);
    int seen = sel_hist[1];
    cyc++;
    sel_hist[1] = sel_hist[0];
    sel_hist[0] = sel_in;
    if (!m_busy) begin
      if (seen != m_last || m_pend || m_idle_seen >= R - 1) begin
        m_busy = 1; m_addr = seen; m_last = seen; m_pend = 0; m_start = cyc;
      end
      m_idle_seen++;
    end else begin
      if (seen != m_last) m_pend = 1;
      if (ack_in) begin
        m_val = d_in; m_valid = 1; m_err = 0; m_idle_seen = 0; m_busy = 0;
      end else if (cyc - m_start == T) begin
        m_err = 1; m_valid = 0; m_busy = 0;
      end
    end
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    logic [31:0] v = m_val >> (4 * i);
    return m_err ? DASH : seg_ref[v[3:0]];
  endfunction

  // ---------------- stimulus ----------------
  bit         rst_drv;
  int         sel_drv;
  int         lat_fix;   // 0: random ack latency per transaction
  bit         stray_en;
  int         age, lat;

  task automatic check_all();
    chk("req", dbg_rd_req, m_busy);
    chk("addr", dbg_rd_addr, m_addr);
    chk("valid", dbg_valid, m_valid);
    for (int i = 0; i < 8; i++) chk($sformatf("hex%0d", i), hex_w[i], exp_seg(i));
  endtask

  task automatic respond();
    if (dbg_rd_req && !reset) begin
      if (age == 0) lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 20));
      age++;
      dbg_rd_ack  = (age == lat);
      dbg_rd_data = dbg_rd_ack ? regs[dbg_rd_addr] : $urandom;
    end else begin
      age = 0;
      dbg_rd_ack  = stray_en && ($urandom_range(0, 3) == 0);
      dbg_rd_data = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    reset = rst_drv;
    respond();
    Debug_selector = SEL_W'(sel_drv);
    @(posedge clk);
    if (reset) model_reset();
    else model_step(int'(Debug_selector), dbg_rd_ack, dbg_rd_data);
  endtask

  initial begin
    int reqcnt;
    bit seen;
    reset = 1'b1; rst_drv = 1'b1;
    Debug_selector = '0; sel_drv = 0;
    dbg_rd_ack = 1'b0; dbg_rd_data = '0;
    stray_en = 0; lat_fix = 1; age = 0; lat = 0; cyc = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[2] = 32'h1234ABCD;
    model_reset();

    // reset state
    repeat (3) tick();
    #2;
    for (int i = 0; i < 8; i++) chk($sformatf("rst_hex%0d", i), hex_w[i], ZERO);
    chk("rst_req", dbg_rd_req, 1'b0);
    chk("rst_valid", dbg_valid, 1'b0);
    rst_drv = 0;
    repeat (4) tick();
    #2 chk("idle_after_rst", dbg_rd_req, 1'b0);

    // basic read: display updates 3 edges after the selector change
    sel_drv = 2;
    repeat (4) tick();
    #2;
    chk("basic_addr", dbg_rd_addr, 2);
    chk("basic_hex0", HEX0, 7'b0100001);
    chk("basic_hex7", HEX7, 7'b1111001);
    chk("basic_valid", dbg_valid, 1'b1);

    // periodic refresh picks up a changed register
    regs[2] = 32'h00000005;
    repeat (R + 6) tick();
    #2;
    chk("refresh_hex0", HEX0, 7'b0010010);
    chk("refresh_hex1", HEX1, ZERO);
    chk("refresh_hex7", HEX7, ZERO);

    // selector change while a slow read of register 2 is outstanding
    lat_fix = 5;
    seen = 0;
    for (int i = 0; i < R + 10 && !seen; i++) begin
      tick();
      #2 seen = dbg_rd_req;
    end
    chk("wait_req", seen, 1'b1);
    regs[7] = 32'hFEDC0000;
    sel_drv = 7;
    repeat (20) tick();
    #2;
    chk("chg_addr", dbg_rd_addr, 7);
    chk("chg_hex7", HEX7, 7'b0001110);
    chk("chg_hex0", HEX0, ZERO);

    // timeout: request held exactly T cycles, then dashes
    lat_fix = 1000;
    sel_drv = 9;
    reqcnt = 0;
    repeat (30) begin
      tick();
      #2 if (dbg_rd_req) reqcnt++;
    end
    chk("tmo_len", reqcnt, T);
    for (int i = 0; i < 8; i++) chk($sformatf("tmo_hex%0d", i), hex_w[i], DASH);
    chk("tmo_valid", dbg_valid, 1'b0);
    lat_fix = 1;
    regs[4] = 32'h89ABCDEF;
    sel_drv = 4;
    repeat (6) tick();
    #2;
    chk("recover_hex0", HEX0, 7'b0001110);
    chk("recover_hex7", HEX7, 7'b0000000);
    chk("recover_valid", dbg_valid, 1'b1);

    // stray acks while idle must be ignored
    stray_en = 1;
    repeat (30) tick();
    stray_en = 0;

    // reset in the middle of a transaction
    lat_fix = 1000;
    sel_drv = 11;
    repeat (5) tick();
    #2 chk("pre_rst_req", dbg_rd_req, 1'b1);
    rst_drv = 1;
    tick();
    #2;
    chk("midrst_req", dbg_rd_req, 1'b0);
    chk("midrst_valid", dbg_valid, 1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("midrst_hex%0d", i), hex_w[i], ZERO);
    sel_drv = 0;
    repeat (2) tick();
    rst_drv = 0;
    lat_fix = 0;

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 24) == 0) sel_drv = int'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) regs[$urandom_range(0, 31)] = $urandom;
      if ($urandom_range(0, 99) == 0) stray_en = ~stray_en;
      if (n == 1000) rst_drv = 1;
      if (n == 1003) rst_drv = 0;
      tick();
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_reg_reader.md
# debug_reg_reader

Debugger front end between the MIPS core's register-file debug read port and the board's eight seven-segment displays. It synchronises the 5-bit `Debug_selector` switch input and issues req/ack reads of the selected register. It re-reads periodically so the display tracks live contents, and drives `HEX7..HEX0` with the 32-bit value in hexadecimal. A read-port timeout is handled by showing dashes.

## Interface

Parameters:
- `DATA_W`, 32, width of the register value read back.
- `SEL_W`, 5, width of the selector and read address.
- `REFRESH_CYCLES`, 1024, idle cycles between automatic re-reads (≥ 4).
- `TIMEOUT_CYCLES`, 16, cycles `dbg_rd_req` may stay high without ack before abort (≥ 2).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Debug_selector`  in  SEL_W  register index from board switches; asynchronous to `clk`.
- `dbg_rd_req`  out  1  read request to the register-file debug port.
- `dbg_rd_addr`  out  SEL_W  register index; stable while `dbg_rd_req` is high.
- `dbg_rd_ack`  in  1  one-cycle read completion strobe.
- `dbg_rd_data`  in  DATA_W  read data, valid in the cycle `dbg_rd_ack` is high.
- `dbg_valid`  out  1  high when the displayed value came from a successful read.
- `HEX0`..`HEX7`  out  7 each  active-low segments {g,f,e,d,c,b,a}; `HEX0` shows bits [3:0], `HEX7` shows bits [31:28].

## Operation

- **Selector sync:** `Debug_selector` passes through a 2-flop synchroniser, giving `sel_s`.
- **FSM states:** IDLE, REQ.
- **IDLE → REQ** when any of these holds:
  - `sel_s` ≠ `last_addr`;
  - `pending` is set;
  - the refresh counter reaches `REFRESH_CYCLES-1`.
- **Entering REQ:** `dbg_rd_addr` ← `sel_s`, `last_addr` ← `sel_s`, `pending` cleared, timeout counter cleared. `dbg_rd_req` is high throughout REQ.
- **REQ with `dbg_rd_ack`=1:**
  - `value` ← `dbg_rd_data`, `dbg_valid` ← 1, `err` ← 0.
  - Refresh counter cleared; return to IDLE.
- **REQ with timeout counter = `TIMEOUT_CYCLES-1` and no ack:** `err` ← 1, `dbg_valid` ← 0, `value` unchanged; return to IDLE.
- **Selector change while in REQ:** the transaction is not aborted and the address does not change. `pending` is set and a new read starts on the first IDLE cycle.
- **Ack while in IDLE:** ignored.
- **Refresh counter:** counts only in IDLE. It saturates at the threshold until the read starts.
- **Display:**
  - `err`=0: each HEX digit = seven-segment encoding of its nibble of `value`, digits 0–F.
  - `err`=1: all digits show dash 7'b0111111.
- **Reset** (asynchronous, also mid-transaction):
  - state IDLE, `dbg_rd_req`=0, `dbg_rd_addr`=0, `last_addr`=0;
  - `pending`=0, `value`=0, `err`=0, `dbg_valid`=0, counters 0, synchroniser flops 0;
  - all HEX outputs = 7'b1000000 ("0").
- **Immediately after reset deassertion:** no read until the selector differs from 0 or the refresh interval expires.

## Timing

- **Edge numbering:** `Debug_selector` changes before edge 0.
  - `sel_s` updates at edge 1.
  - `dbg_rd_req` rises at edge 2.
  - Earliest ack is sampled at edge 3; `value` and the HEX outputs update at edge 3.
  - `dbg_rd_req` is low after edge 3.
- **Minimum selector-to-display latency:** 3 cycles plus ack wait.
- **Back-to-back reads:** one IDLE cycle between completion and the next `dbg_rd_req` assertion, so the request is never high on two consecutive transactions without a low cycle.
- **Timeout:** `dbg_rd_req` is high for exactly `TIMEOUT_CYCLES` cycles, then low.
- **HEX outputs:** combinational decode of registered `value`/`err`, so they are glitch-free relative to `clk`.

## Structure

- Shared debug package holds:
  - seven-segment constants `SEG_DASH`, `SEG_ZERO`, and the 16-entry digit table;
  - FSM state typedef;
  - `SEL_W` default.
- One combinational sub-module `hex_to_7seg` (4-bit nibble → 7-bit active-low segments), instantiated eight times.
- The synchroniser, FSM, counters and value register live in `debug_reg_reader`.

## Test plan

- **Reset:** hold reset with selector 0 → `HEX0..7`=7'b1000000, `dbg_valid`=0, `dbg_rd_req`=0, including when reset asserts mid-REQ.
- **Basic read:** selector 0 → 2 after reset; model acks the next cycle with 32'h1234ABCD → `dbg_rd_addr`=2, req high 1 cycle, `HEX0`=D (7'b0100001), `HEX7`=1 (7'b1111001), `dbg_valid`=1, 3 cycles after the change.
- **Refresh:** selector steady at 2; model changes register 2 to 32'h00000005 → a re-read occurs after `REFRESH_CYCLES` idle cycles, `HEX0`=5 (7'b0010010), other digits "0".
- **Change during REQ:** model delays ack 5 cycles on addr 2; selector → 7 during the wait → addr 2 data latched first, then one idle cycle, then req with `dbg_rd_addr`=7.
- **Timeout:** model never acks → req high exactly 16 cycles, then all HEX = 7'b0111111, `dbg_valid`=0. A later successful read clears the dashes.
- **Stray ack:** ack pulses while IDLE → no change to `value`, HEX, or FSM state.
